// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM state and arbiter ownership types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I} arb_owner_t;
endpackage

// File: rtl/mem_arb_fair.sv
// mem_arb_fair: dcache completion streak and icache favour flag
module mem_arb_fair #(
  parameter int DLIMIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic dcomp,
  input  logic icomp,
  input  logic rel,
  input  logic iREN,
  output logic ifavor
);
  localparam int SW = $clog2(DLIMIT + 2) + 1;
  logic [SW-1:0] streak_q, streak_d, raw, sinc;
  logic ifavor_q, ifavor_d;
  // streak folds back by two past DLIMIT+1 so its threshold and parity stay exact
  always_comb begin
    raw = streak_q + SW'(1);
    sinc = (raw > SW'(DLIMIT + 1)) ? raw - SW'(2) : raw;
    streak_d = dcomp ? sinc : (icomp || rel) ? '0 : streak_q;
    ifavor_d = icomp ? 1'b0 : (dcomp && sinc >= SW'(DLIMIT) && iREN && !sinc[0]) ? 1'b1 : ifavor_q;
  end
  // fairness state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      streak_q <= '0;
      ifavor_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      ifavor_q <= ifavor_d;
    end
  end
  assign ifavor = ifavor_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: zero-latency dcache/icache arbitration onto one RAM port
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DLIMIT = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dREN,
  input  logic             dWEN,
  input  word_t            daddr,
  input  word_t            dstore,
  output logic             dwait,
  output word_t            dload,
  input  logic             iREN,
  input  word_t            iaddr,
  output logic             iwait,
  output word_t            iload,
  output logic             ramREN,
  output logic             ramWEN,
  output word_t            ramaddr,
  output word_t            ramstore,
  input  word_t            ramload,
  input  ramstate_t        ramstate,
  output logic             ram_err,
  output logic [CNT_W-1:0] dxfer_cnt,
  output logic [CNT_W-1:0] ixfer_cnt
);
  arb_owner_t owner_q, owner_d, grant;
  logic dreq, acc, dcomp, icomp, rel, ifavor, ram_err_q, ram_err_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d, icnt_q, icnt_d;
  assign dreq = dREN | dWEN;
  // grant: forced icache turn, then sticky owner, then dcache-first default; nothing in reset
  always_comb begin
    grant = OWN_NONE;
    if (!RST)
      grant = (ifavor && iREN) ? OWN_I :
              (owner_q == OWN_D && dreq) ? OWN_D :
              (owner_q == OWN_I && iREN && !dreq) ? OWN_I :
              dreq ? OWN_D : iREN ? OWN_I : OWN_NONE;
  end
  // RAM drive, completion detection and per-side responses
  always_comb begin
    ramWEN = (grant == OWN_D) && dWEN;
    ramREN = (grant == OWN_D) ? (dREN && !dWEN) : (grant == OWN_I);
    ramaddr = (grant == OWN_D) ? daddr : (grant == OWN_I) ? iaddr : '0;
    ramstore = (grant == OWN_D) ? dstore : '0;
    acc = (ramstate == ACCESS) && (ramREN || ramWEN);
    dcomp = acc && (grant == OWN_D);
    icomp = acc && (grant == OWN_I);
    dwait = !dcomp;
    iwait = !icomp;
    dload = (dcomp && ramREN) ? ramload : '0;
    iload = icomp ? ramload : '0;
  end
  // next owner, sticky error and transfer counters
  always_comb begin
    rel = (owner_q == OWN_D && !dreq) || (owner_q == OWN_I && !iREN);
    owner_d = dcomp ? OWN_D : icomp ? OWN_I : rel ? OWN_NONE : owner_q;
    ram_err_d = ram_err_q || (ramstate == ERROR);
    dcnt_d = dcomp ? dcnt_q + CNT_W'(1) : dcnt_q;
    icnt_d = icomp ? icnt_q + CNT_W'(1) : icnt_q;
  end
  // arbiter state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_q <= OWN_NONE;
      ram_err_q <= 1'b0;
      dcnt_q <= '0;
      icnt_q <= '0;
    end else begin
      owner_q <= owner_d;
      ram_err_q <= ram_err_d;
      dcnt_q <= dcnt_d;
      icnt_q <= icnt_d;
    end
  end
  mem_arb_fair #(.DLIMIT(DLIMIT)) u_fair (
    .CLK(CLK),
    .RST(RST),
    .dcomp(dcomp),
    .icomp(icomp),
    .rel(rel),
    .iREN(iREN),
    .ifavor(ifavor)
  );
  assign ram_err = ram_err_q;
  assign dxfer_cnt = dcnt_q;
  assign ixfer_cnt = icnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks against a rule-level model
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  localparam int DLIMIT = 4;
  logic CLK = 0, RST = 1;
  logic dREN = 0, dWEN = 0, iREN = 0;
  word_t daddr = 0, dstore = 0, iaddr = 0, ramload = 0;
  ramstate_t ramstate = FREE;
  logic dwait, iwait, ramREN, ramWEN, ram_err;
  word_t dload, iload, ramaddr, ramstore;
  logic [31:0] dxfer_cnt, ixfer_cnt;
  int total = 0, bad = 0;
  int m_owner, m_streak, m_dc, m_ic;
  bit m_fav, m_err, last_dc, last_ic;

  mem_arbiter #(.DLIMIT(DLIMIT), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err),
    .dxfer_cnt(dxfer_cnt), .ixfer_cnt(ixfer_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_owner = 0; m_streak = 0; m_dc = 0; m_ic = 0; m_fav = 0; m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1; dREN = 0; dWEN = 0; iREN = 0; ramstate = FREE;
    #1;
    chk("rst_dwait", dwait, 1); chk("rst_iwait", iwait, 1);
    chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
    chk("rst_dload", dload, 0); chk("rst_iload", iload, 0);
    chk("rst_err", ram_err, 0); chk("rst_dcnt", dxfer_cnt, 0); chk("rst_icnt", ixfer_cnt, 0);
    @(negedge CLK);
    RST = 0;
    model_clear();
  endtask

  // one cycle: drive at negedge, compare against rule model, advance model
  task automatic step(input bit dr, input bit dw, input word_t da, input word_t ds,
                      input bit ir, input word_t ia, input logic [1:0] rs, input word_t rl);
    int g;
    bit dq, e_ren, e_wen, acc;
    @(negedge CLK);
    dREN = dr; dWEN = dw; daddr = da; dstore = ds; iREN = ir; iaddr = ia;
    ramstate = ramstate_t'(rs); ramload = rl;
    #1;
    chk("dxfer_cnt", dxfer_cnt, 64'(m_dc)); chk("ixfer_cnt", ixfer_cnt, 64'(m_ic));
    chk("ram_err", ram_err, 64'(m_err));
    dq = dr | dw;
    if (m_fav && ir) g = 2;
    else if (m_owner == 1 && dq) g = 1;
    else if (m_owner == 2 && ir && !dq) g = 2;
    else g = dq ? 1 : ir ? 2 : 0;
    e_wen = (g == 1) && dw;
    e_ren = (g == 1) ? (dr && !dw) : (g == 2);
    acc = (rs == 2'd2) && (e_ren || e_wen);
    last_dc = acc && g == 1;
    last_ic = acc && g == 2;
    chk("ramWEN", ramWEN, 64'(e_wen)); chk("ramREN", ramREN, 64'(e_ren));
    chk("ramaddr", ramaddr, g == 1 ? 64'(da) : g == 2 ? 64'(ia) : 0);
    chk("ramstore", ramstore, g == 1 ? 64'(ds) : 0);
    chk("dwait", dwait, 64'(!last_dc)); chk("iwait", iwait, 64'(!last_ic));
    if (last_dc) chk("dload", dload, e_ren ? 64'(rl) : 0);
    if (last_ic) chk("iload", iload, 64'(rl));
    if ((m_owner == 1 && !dq) || (m_owner == 2 && !ir)) begin
      m_owner = 0; m_streak = 0;
    end
    if (rs == 2'd3) m_err = 1;
    if (last_dc) begin
      m_dc++; m_streak++; m_owner = 1;
      if (m_streak >= DLIMIT && ir && m_streak % 2 == 0) m_fav = 1;
    end
    if (last_ic) begin
      m_ic++; m_streak = 0; m_fav = 0; m_owner = 2;
    end
  endtask

  initial begin
    int idx, d_at_i, dop, iop;
    bit idone;
    bit [5:0] ops;
    word_t da, ds, ia;
    model_clear();
    do_reset();
    // icache read with two BUSY cycles
    step(0, 0, 0, 0, 1, 32'h40, 2'd1, 0);
    step(0, 0, 0, 0, 1, 32'h40, 2'd1, 0);
    step(0, 0, 0, 0, 1, 32'h40, 2'd2, 32'hDEADBEEF);
    chk("i_read_done", last_ic, 1);
    chk("i_read_load", iload, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);
    chk("i_read_cnt", ixfer_cnt, 1);
    // reset in the middle of a BUSY access drops the strobe at once
    step(0, 0, 0, 0, 1, 32'h44, 2'd1, 0);
    @(negedge CLK);
    RST = 1;
    #1;
    chk("rst_mid_ramREN", ramREN, 0);
    chk("rst_mid_iwait", iwait, 1);
    do_reset();
    // simultaneous first requests
    step(1, 0, 32'h100, 0, 1, 32'h200, 2'd2, 32'h11);
    chk("sim_d_first", dwait, 0);
    step(0, 0, 0, 0, 1, 32'h200, 2'd2, 32'h22);
    chk("sim_i_second", iwait, 0);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);
    chk("sim_dcnt", dxfer_cnt, 1); chk("sim_icnt", ixfer_cnt, 1);
    // WB,WB,LD,LD,WB,WB burst against a held icache request
    do_reset();
    ops = 6'b110011;
    idx = 0; idone = 0; d_at_i = -1;
    for (int c = 0; c < 20 && (idx < 6 || !idone); c++) begin
      if (idx < 6) step(!ops[idx], ops[idx], 32'h3000 + idx, idx, !idone, 32'h80, 2'd2, 32'h55);
      else step(0, 0, 0, 0, !idone, 32'h80, 2'd2, 32'h55);
      if (last_ic && !idone) begin idone = 1; d_at_i = idx; end
      if (last_dc) idx++;
    end
    chk("burst_all_done", {idx[7:0], 7'd0, idone}, {8'd6, 8'd1});
    chk("burst_i_after", d_at_i, DLIMIT);
    // write has priority over read
    do_reset();
    step(1, 1, 32'h3100, 7, 0, 0, 2'd1, 0);
    chk("wpri_ramWEN", ramWEN, 1); chk("wpri_ramREN", ramREN, 0);
    chk("wpri_ramstore", ramstore, 7); chk("wpri_ramaddr", ramaddr, 32'h3100);
    // ERROR retried then completes once
    do_reset();
    step(1, 0, 32'h500, 0, 0, 0, 2'd3, 0);
    step(1, 0, 32'h500, 0, 0, 0, 2'd3, 0);
    chk("err_still_wait", dwait, 1);
    step(1, 0, 32'h500, 0, 0, 0, 2'd2, 32'hABCD);
    chk("err_done", dwait, 0);
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);
    chk("err_sticky", ram_err, 1); chk("err_dcnt", dxfer_cnt, 1);
    // random traffic: requesters hold until served, occasionally abandon
    do_reset();
    dop = 0; iop = 0; da = 0; ds = 0; ia = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [1:0] rs;
      if (dop == 0 && $urandom_range(0, 2) != 0) begin
        dop = $urandom_range(1, 3); da = $urandom; ds = $urandom;
      end else if (dop != 0 && $urandom_range(0, 30) == 0) dop = 0;
      if (iop == 0 && $urandom_range(0, 2) != 0) begin
        iop = 1; ia = $urandom;
      end else if (iop != 0 && $urandom_range(0, 30) == 0) iop = 0;
      r = $urandom_range(0, 19);
      rs = r < 10 ? 2'd2 : r < 15 ? 2'd1 : r < 18 ? 2'd0 : 2'd3;
      step(dop[0], dop[1], da, ds, iop != 0, ia, rs, $urandom);
      if (last_dc) dop = 0;
      if (last_ic) iop = 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the dcache and icache. Arbitrates their single-word RAM requests onto the one RAM port and returns dwait/iwait/dload/iload.
- Honors the dcache's back-to-back bursts: WB1/WB2 and LD1/LD2 stay on the port together.
- A bounded fairness rule guarantees icache progress.
- Keeps sticky error status and per-side transfer counters for the perf/halt dump.

Parameters:
- DLIMIT, 4, consecutive dcache completions allowed while iREN is pending before icache is forced in. Must be even and ≥2.
- CNT_W, 32, width of the transfer counters.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for exactly the cycle the dcache access completes
- dload  out  32  read data to dcache
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the cycle the icache access completes
- iload  out  32  read data to icache
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ram_err  out  1  sticky: ERROR was seen
- dxfer_cnt  out  CNT_W  completed dcache accesses
- ixfer_cnt  out  CNT_W  completed icache accesses

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. Ports are CLK and RST.
- Registered state (all cleared by RST):
  - owner (NONE/D/I)
  - dstreak (consecutive dcache completions)
  - ifavor
  - ram_err
  - both counters
- Reset values of outputs: dwait=1, iwait=1, dload=0, iload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, ram_err=0, counters=0.
- RST asserted mid-access drops ramREN/ramWEN combinationally. The in-flight access is abandoned and never completed.
- Grant selection (combinational, each cycle):
  - If ifavor and iREN: grant I.
  - Else if owner==D and dcache is requesting: grant D.
  - Else if owner==I and iREN and no dcache request: grant I.
  - Else dcache request → D; else iREN → I; else none.
- RAM drive follows the grant in the same cycle.
  - D: dWEN has priority over dREN. ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
  - I: ramREN=1, ramaddr=iaddr, ramstore=0.
  - None: all zero.
- Completion occurs when ramstate==ACCESS while a strobe is driven.
  - The granted side's wait goes to 0 that cycle only; the other wait stays 1.
  - The load output is ramload on a read grant and 0 otherwise. The other side's load is 0.
- On D completion:
  - dxfer_cnt+1 and dstreak+1; owner←D.
  - If dstreak+1 ≥ DLIMIT, iREN is high, and dstreak+1 is even: set ifavor. This switches only at burst boundaries.
- On I completion:
  - ixfer_cnt+1, dstreak←0, ifavor←0, owner←I.
- Owner release: a cycle in which the owner is not requesting sets owner←NONE and dstreak←0.
- FREE/BUSY: hold the strobes; both waits stay 1.
- ERROR:
  - Set ram_err (sticky until RST).
  - Waits stay 1 and strobes stay asserted, so the access is retried next cycle. No completion is counted.
- Latency: zero-cycle arbitration. A lone request is presented to RAM in the cycle it is asserted.
- Simultaneous first requests: dcache wins.
- A requester dropping its request mid-access cancels it with no completion.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- In cpu_types_pkg: word_t, ramstate_t (existing), and a new arb_owner_t enum {OWN_NONE, OWN_D, OWN_I}.
- No sub-module is required. The fairness streak/ifavor logic may optionally be split into mem_arb_fair.

Test Plan:
- Reset with all inputs idle → dwait=iwait=1, strobes 0, counters 0. Assert RST during a BUSY access → ramREN drops the same cycle.
- iREN with iaddr=0x40, ramstate BUSY×2 then ACCESS with ramload=0xDEADBEEF → iwait low exactly on cycle 3, iload=0xDEADBEEF, ixfer_cnt=1.
- dREN and iREN rise in the same cycle, RAM 1-cycle ACCESS → dcache served first (dwait low), then icache next access; dxfer_cnt=1, ixfer_cnt=1.
- dcache issues WB1,WB2,LD1,LD2,WB1,WB2 continuously with iREN held → icache granted only after the 4th dcache completion (DLIMIT=4). WB pair and LD pair are never split.
- dWEN=dREN=1, daddr=0x3100, dstore=7 → ramWEN=1, ramREN=0, ramstore=7.
- ERROR for 2 cycles then ACCESS → ram_err=1 stays high, dwait low only on the ACCESS cycle, dxfer_cnt increments once.
